// File: rtl/regfile_writer.sv
// Write-side controller for the register file: queues upstream writes, drains one per clock, or loads INIT_BASE+addr.
// Queued write reaches rf_* one edge after it is buffered; req_ready drops while the request FIFO is full.
module regfile_writer #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 3,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] INIT_BASE  = 8'hAA
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_data,
  input  logic                        init_start,
  output logic                        rf_load,
  output logic [ADDR_W-1:0]           rf_addr,
  output logic [DATA_W-1:0]           rf_d_in,
  output logic                        busy,
  output logic                        init_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    INIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_e            state_q, state_d;
  req_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              rf_load_q, rf_load_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_d_in_q, rf_d_in_d;
  logic              init_done_q, init_done_d;
  logic              push, pop, fifo_nempty;
  req_t              head;

  assign fifo_nempty = (count_q != '0);
  assign req_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push        = req_valid && req_ready;
  assign head        = mem_q[rd_ptr_q];

  // Pop decisions use the registered count, so an entry is never popped on the edge that pushes it.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    pop         = 1'b0;
    rf_load_d   = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_d_in_d   = rf_d_in_q;
    init_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end else if (fifo_nempty) begin
          state_d = DRAIN;
          pop     = 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_nempty) pop = 1'b1;
        else             state_d = IDLE;
      end
      INIT: begin
        rf_load_d  = 1'b1;
        rf_addr_d  = init_cnt_q;
        rf_d_in_d  = INIT_BASE + DATA_W'(init_cnt_q);
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST_ADDR) begin
          init_done_d = 1'b1;
          state_d     = fifo_nempty ? DRAIN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      rf_load_d = 1'b1;
      rf_addr_d = head.addr;
      rf_d_in_d = head.data;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      init_cnt_q  <= '0;
      rf_load_q   <= 1'b0;
      rf_addr_q   <= '0;
      rf_d_in_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      init_cnt_q  <= init_cnt_d;
      rf_load_q   <= rf_load_d;
      rf_addr_q   <= rf_addr_d;
      rf_d_in_q   <= rf_d_in_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: req_addr, data: req_data};
  end

  assign rf_load    = rf_load_q;
  assign rf_addr    = rf_addr_q;
  assign rf_d_in    = rf_d_in_q;
  assign init_done  = init_done_q;
  assign busy       = (state_q != IDLE) || fifo_nempty;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: directed scenarios plus random traffic against a queue-based reference model.
module tb_regfile_writer;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int M_IDLE = 0, M_DRAIN = 1, M_INIT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          init_start = 1'b0;
  logic          rf_load;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d_in;
  logic          busy;
  logic          init_done;
  logic [LW-1:0] fifo_level;

  regfile_writer #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .INIT_BASE(8'hAA)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .init_start(init_start),
    .rf_load(rf_load), .rf_addr(rf_addr), .rf_d_in(rf_d_in), .busy(busy),
    .init_done(init_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t mq[$];    // model FIFO contents
  wr_t stim[$];  // pending upstream requests, head presented on req_*
  wr_t wlog[$];  // writes seen on the register-file port
  int  mode, icnt, exp_load, exp_addr, exp_data, exp_done;
  int  rf_arr[8];
  int  n_assert = 0, n_fail = 0;
  int  cyc_n = 0, done_cnt = 0, done_addr = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    stim.delete();
    mode = M_IDLE; icnt = 0;
    exp_load = 0; exp_addr = 0; exp_data = 0; exp_done = 0;
    req_valid = 1'b0; init_start = 1'b0;
  endtask

  task automatic issue_head();
    wr_t w;
    w = mq.pop_front();
    exp_load = 1; exp_addr = w.addr; exp_data = w.data;
  endtask

  // One rising edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_step(output bit pushed);
    bit  have;
    wr_t w;
    pushed = req_valid && (mq.size() < DEPTH);
    have   = mq.size() > 0;
    exp_load = 0; exp_done = 0;
    case (mode)
      M_IDLE: begin
        if (init_start) begin mode = M_INIT; icnt = 0; end
        else if (have) begin issue_head(); mode = M_DRAIN; end
      end
      M_DRAIN: begin
        if (have) issue_head();
        else mode = M_IDLE;
      end
      default: begin
        exp_load = 1; exp_addr = icnt; exp_data = (8'hAA + icnt) % 256;
        if (icnt == 7) begin
          exp_done = 1;
          mode = have ? M_DRAIN : M_IDLE;
        end
        icnt++;
      end
    endcase
    if (pushed) begin
      w.addr = req_addr; w.data = req_data; w.cyc = cyc_n;
      mq.push_back(w);
    end
  endtask

  task automatic check_all();
    wr_t w;
    chk("rf_load", rf_load, exp_load);
    chk("rf_addr", rf_addr, exp_addr);
    chk("rf_d_in", rf_d_in, exp_data);
    chk("init_done", init_done, exp_done);
    chk("busy", busy, (mode != M_IDLE) || (mq.size() > 0));
    chk("fifo_level", fifo_level, mq.size());
    chk("req_ready", req_ready, mq.size() < DEPTH);
    if (rf_load === 1'b1) begin
      rf_arr[rf_addr] = int'(rf_d_in);
      w.addr = int'(rf_addr); w.data = int'(rf_d_in); w.cyc = cyc_n;
      wlog.push_back(w);
    end
    if (init_done === 1'b1) begin
      done_cnt++;
      done_addr = int'(rf_addr);
    end
  endtask

  task automatic push_req(input int a, input int d);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = 0;
    stim.push_back(w);
  endtask

  task automatic cycle();
    bit pushed;
    req_valid = (stim.size() > 0);
    if (stim.size() > 0) begin
      req_addr = AW'(stim[0].addr);
      req_data = DW'(stim[0].data);
    end
    @(posedge clk);
    model_step(pushed);
    #1;
    cyc_n++;
    check_all();
    if (pushed) void'(stim.pop_front());
  endtask

  initial begin
    int  n;
    bit  drained;
    model_reset();
    for (int i = 0; i < 8; i++) rf_arr[i] = -1;

    // Reset state
    #2;
    chk("rst_rf_load", rf_load, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_d_in", rf_d_in, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", req_ready, 1);
    #10 reset = 1'b1;

    // Single write latency
    push_req(3, 'h5C);
    cycle();
    chk("t1_no_write_yet", rf_load, 0);
    cycle();
    chk("t1_load", rf_load, 1);
    chk("t1_addr", rf_addr, 3);
    chk("t1_data", rf_d_in, 'h5C);
    cycle();
    chk("t1_load_off", rf_load, 0);
    chk("t1_busy_off", busy, 0);
    chk("t1_level", fifo_level, 0);

    // Init sequence and readback
    wlog.delete(); done_cnt = 0;
    init_start = 1'b1; cycle(); init_start = 1'b0;
    repeat (8) cycle();
    cycle();
    chk("t3_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk("t3_addr", wlog[i].addr, i);
      chk("t3_data", wlog[i].data, 8'hAA + i);
      chk("t3_consec", wlog[i].cyc, wlog[0].cyc + i);
    end
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_addr", done_addr, 7);
    for (int i = 0; i < 8; i++) chk("t3_readback", rf_arr[i], 8'hAA + i);

    // init_start and a request on the same edge
    wlog.delete();
    init_start = 1'b1; push_req(1, 'h11); cycle(); init_start = 1'b0;
    repeat (10) cycle();
    chk("t4_nwrites", wlog.size(), 9);
    if (wlog.size() == 9) begin
      chk("t4_last_addr", wlog[8].addr, 1);
      chk("t4_last_data", wlog[8].data, 'h11);
    end
    chk("t4_reg1", rf_arr[1], 'h11);
    chk("t4_reg0", rf_arr[0], 'hAA);

    // Back-to-back requests stalled behind init
    wlog.delete();
    init_start = 1'b1;
    for (int i = 0; i < 6; i++) push_req(7 - i, 'h30 + i);
    cycle(); init_start = 1'b0;
    repeat (4) cycle();
    chk("t2_level_full", fifo_level, 4);
    chk("t2_ready_low", req_ready, 0);
    n = 0;
    while (wlog.size() < 14 && n < 40) begin cycle(); n++; end
    chk("t2_bound", n < 40, 1);
    repeat (2) cycle();
    chk("t2_nwrites", wlog.size(), 14);
    for (int i = 0; i < 6 && wlog.size() == 14; i++) begin
      chk("t2_order_addr", wlog[8 + i].addr, 7 - i);
      chk("t2_order_data", wlog[8 + i].data, 'h30 + i);
      chk("t2_one_per_cycle", wlog[8 + i].cyc, wlog[0].cyc + 8 + i);
    end

    // Asynchronous reset in the middle of a drain
    init_start = 1'b1;
    for (int i = 0; i < 4; i++) push_req(i, 'h60 + i);
    cycle(); init_start = 1'b0;
    repeat (9) cycle();
    chk("t5_level_pre", fifo_level, 3);
    chk("t5_load_pre", rf_load, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_load_async", rf_load, 0);
    chk("t5_level_async", fifo_level, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_ready_async", req_ready, 1);
    model_reset();
    #3 reset = 1'b1;
    wlog.delete();
    repeat (6) cycle();
    chk("t5_no_writes", wlog.size(), 0);

    // Streaming one request per cycle
    wlog.delete();
    for (int i = 0; i < 10; i++) push_req(i % 8, 'hC0 + i);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t6_level", fifo_level, 1);
    end
    repeat (3) cycle();
    chk("t6_nwrites", wlog.size(), 10);
    for (int i = 0; i < 10 && wlog.size() == 10; i++) begin
      chk("t6_addr", wlog[i].addr, i % 8);
      chk("t6_data", wlog[i].data, 'hC0 + i);
    end

    // Random traffic against the model
    repeat (300) begin
      if (stim.size() == 0 && $urandom_range(0, 9) < 7)
        push_req($urandom_range(0, 7), $urandom_range(0, 255));
      init_start = ($urandom_range(0, 19) == 0);
      cycle();
      init_start = 1'b0;
    end
    n = 0;
    drained = 1'b0;
    while (!drained && n < 100) begin
      cycle();
      n++;
      drained = (stim.size() == 0) && (mode == M_IDLE) && (mq.size() == 0);
    end
    chk("rand_drain_bound", drained, 1);
    chk("rand_final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
